// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the Wishbone arbiter and related interconnect blocks.
package wb_arbiter_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StOwn  = 1'b1
    } arb_state_e;

    localparam int unsigned RrModeFixed = 0;
    localparam int unsigned RrModeRound = 1;

    // Ceiling log2, never less than 1 so it can size a register directly.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                width = i + 1;
            end
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational one-hot winner select: fixed priority (lowest index) or round-robin
// starting just after rr_ptr_i.
module wb_arb_pick
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NumReq = 2,
    parameter int unsigned PtrW   = clog2_min1(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [PtrW-1:0]   rr_ptr_i,
    input  logic              rr_mode_i,
    output logic [NumReq-1:0] grant_o
);

    int unsigned best_rank;

    // Search order position of a requester; lower wins. Ranks are distinct, so the
    // result is one-hot.
    function automatic int unsigned rank(input int unsigned idx, input int unsigned ptr,
                                         input logic rr);
        if (rr) begin
            return (idx + NumReq - ptr - 1) % NumReq;
        end
        return idx;
    endfunction

    always_comb begin
        best_rank = NumReq;
        for (int unsigned j = 0; j < NumReq; j++) begin
            if (req_i[j] && (rank(j, 32'(rr_ptr_i), rr_mode_i) < best_rank)) begin
                best_rank = rank(j, 32'(rr_ptr_i), rr_mode_i);
            end
        end
        grant_o = '0;
        for (int unsigned j = 0; j < NumReq; j++) begin
            grant_o[j] = req_i[j] && (rank(j, 32'(rr_ptr_i), rr_mode_i) == best_rank);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// N-master to 1-slave Wishbone arbiter with fixed-priority or round-robin selection
// and a per-strobe ack timeout that terminates with an error.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned RR_MODE     = 0,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_addr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_data_i,
    output logic [DW-1:0]               m_data_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic [AW-1:0]               s_addr_o,
    output logic [DW-1:0]               s_data_o,
    input  logic [DW-1:0]               s_data_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        busy_o
);

    localparam int unsigned SW   = DW / 8;
    localparam int unsigned PtrW = clog2_min1(NUM_MASTERS);
    localparam int unsigned TmoW = clog2_min1(TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [TmoW-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                   tmo_block_q;

    logic [NUM_MASTERS-1:0] pick_grant;
    logic [PtrW-1:0]        grant_idx;
    logic                   own_cyc;
    logic                   tmo_hit;

    wb_arb_pick #(
        .NumReq (NUM_MASTERS),
        .PtrW   (PtrW)
    ) u_pick (
        .req_i     (m_cyc_i),
        .rr_ptr_i  (rr_ptr_q),
        .rr_mode_i (RR_MODE == RrModeRound),
        .grant_o   (pick_grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                grant_idx = PtrW'(k);
            end
        end
    end

    assign own_cyc = |(grant_q & m_cyc_i);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            StIdle: begin
                if (|m_cyc_i) begin
                    state_d = StOwn;
                    grant_d = pick_grant;
                end
            end
            StOwn: begin
                if (!own_cyc) begin
                    state_d = StIdle;
                    grant_d = '0;
                    if (RR_MODE == RrModeRound) begin
                        rr_ptr_d = grant_idx;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    // grant_q is zero outside OWN, so the AND-OR mux also yields the all-zero idle bus.
    always_comb begin
        s_sel_o  = '0;
        s_addr_o = '0;
        s_data_o = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                s_sel_o  = s_sel_o  | m_sel_i[k*SW +: SW];
                s_addr_o = s_addr_o | m_addr_i[k*AW +: AW];
                s_data_o = s_data_o | m_data_i[k*DW +: DW];
            end
        end
    end

    assign s_cyc_o = own_cyc;
    assign s_we_o  = |(grant_q & m_we_i);
    assign s_stb_o = (|(grant_q & m_stb_i)) && !tmo_block_q;

    assign tmo_hit = (TIMEOUT != 0) && (state_q == StOwn) && s_stb_o && !s_ack_i && !s_err_i
                     && (tmo_cnt_q == TmoLast);

    always_comb begin
        tmo_cnt_d = '0;
        if ((TIMEOUT != 0) && (state_q == StOwn) && own_cyc && s_stb_o && !s_ack_i && !s_err_i
            && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            tmo_cnt_q   <= '0;
            tmo_block_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_block_q <= tmo_hit;
        end
    end

    assign m_data_o = s_data_i;
    assign m_ack_o  = grant_q & {NUM_MASTERS{s_ack_i}};
    assign m_err_o  = grant_q & {NUM_MASTERS{s_err_i | tmo_hit}};
    assign grant_o  = grant_q;
    assign busy_o   = (state_q == StOwn);

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench: a 2-master fixed-priority arbiter (TIMEOUT=8) and a 3-master
// round-robin arbiter (timeout disabled).
module tb_wb_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  a_cyc, a_stb, a_we, a_ack, a_err, a_grant;
    logic [7:0]  a_sel;
    logic [63:0] a_addr, a_wdat;
    logic [31:0] a_rdat, a_sdin, a_saddr, a_sdat;
    logic [3:0]  a_ssel;
    logic        a_scyc, a_sstb, a_swe, a_sack, a_serr, a_busy;

    logic [2:0]  b_cyc, b_stb, b_we, b_ack, b_err, b_grant;
    logic [11:0] b_sel;
    logic [95:0] b_addr, b_wdat;
    logic [31:0] b_rdat, b_sdin, b_saddr, b_sdat;
    logic [3:0]  b_ssel;
    logic        b_scyc, b_sstb, b_swe, b_sack, b_serr, b_busy;

    wb_arbiter #(.NUM_MASTERS(2), .AW(32), .DW(32), .RR_MODE(0), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .m_cyc_i(a_cyc), .m_stb_i(a_stb), .m_we_i(a_we),
        .m_sel_i(a_sel), .m_addr_i(a_addr), .m_data_i(a_wdat), .m_data_o(a_rdat),
        .m_ack_o(a_ack), .m_err_o(a_err), .s_cyc_o(a_scyc), .s_stb_o(a_sstb), .s_we_o(a_swe),
        .s_sel_o(a_ssel), .s_addr_o(a_saddr), .s_data_o(a_sdat), .s_data_i(a_sdin),
        .s_ack_i(a_sack), .s_err_i(a_serr), .grant_o(a_grant), .busy_o(a_busy));

    wb_arbiter #(.NUM_MASTERS(3), .AW(32), .DW(32), .RR_MODE(1), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .m_cyc_i(b_cyc), .m_stb_i(b_stb), .m_we_i(b_we),
        .m_sel_i(b_sel), .m_addr_i(b_addr), .m_data_i(b_wdat), .m_data_o(b_rdat),
        .m_ack_o(b_ack), .m_err_o(b_err), .s_cyc_o(b_scyc), .s_stb_o(b_sstb), .s_we_o(b_swe),
        .s_sel_o(b_ssel), .s_addr_o(b_saddr), .s_data_o(b_sdat), .s_data_i(b_sdin),
        .s_ack_i(b_sack), .s_err_i(b_serr), .grant_o(b_grant), .busy_o(b_busy));

    typedef struct {
        logic [2:0]  grant;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic test_reset();
        rst   = 1'b1;
        a_cyc = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (a_grant !== 2'b00 || a_scyc !== 1'b0 || a_busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc%0d grant=%b s_cyc=%b busy=%b required 00/0/0",
                         i, a_grant, a_scyc, a_busy);
            end
        end
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (a_grant !== 2'b01 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant grant=%b busy=%b required 01/1", a_grant, a_busy);
        end
        a_cyc = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fixed();
        exp_t e;
        int   waited;
        logic m1_seen = 1'b0;
        a_we   = 2'b00;
        a_sel  = 8'hFF;
        a_addr = {32'h0000_2000, 32'h0000_1000};
        a_sdin = 32'hDEAD_BEEF;
        a_cyc  = 2'b11;
        a_stb  = 2'b11;
        for (int n = 0; n < 4; n++) begin
            e.grant = 3'b001; e.addr = 32'h1000; e.data = 32'hDEAD_BEEF; e.sel = 4'hF;
            e.we = 1'b0;
            exp_q.push_back(e);
            waited = 0;
            do begin
                @(negedge clk);
                a_cyc[0] = 1'b1; a_stb[0] = 1'b1;
                #1;
                waited++;
                if (a_grant[1] === 1'b1) m1_seen = 1'b1;
            end while (a_grant === 2'b00 && waited < 8);
            a_sack = 1'b1;
            #1;
            checks++;
            if (a_ack === 2'b00) begin
                failures++;
                $display("FAIL fixed_ack n=%0d ack=%b grant=%b required ack=01", n, a_ack, a_grant);
            end else begin
                e = exp_q.pop_front();
                if (a_ack !== e.grant[1:0] || a_grant !== e.grant[1:0] || a_saddr !== e.addr ||
                    a_rdat !== e.data) begin
                    failures++;
                    $display("FAIL fixed_xfer n=%0d ack=%b grant=%b addr=%h data=%h required %b/%b/%h/%h",
                             n, a_ack, a_grant, a_saddr, a_rdat, e.grant[1:0], e.grant[1:0],
                             e.addr, e.data);
                end
            end
            @(negedge clk);
            a_sack = 1'b0; a_cyc[0] = 1'b0; a_stb[0] = 1'b0;
        end
        checks++;
        if (m1_seen !== 1'b0) begin
            failures++;
            $display("FAIL fixed_m1_never_granted seen=%b required 0", m1_seen);
        end
        a_cyc = 2'b00; a_stb = 2'b00;
        repeat (2) @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_burst();
        exp_t e;
        int   waited = 0;
        a_we = 2'b00; a_stb = 2'b00; a_cyc = 2'b10;
        do begin
            @(negedge clk); #1; waited++;
        end while (a_grant === 2'b00 && waited < 8);
        a_cyc = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_stb[1] = 1'b1;
            a_addr[63:32] = 32'(i * 4);
            a_sdin = 32'hB000_0000 | 32'(i);
            e.grant = 3'b010; e.addr = 32'(i * 4); e.data = 32'hB000_0000 | 32'(i);
            e.sel = 4'hF; e.we = 1'b0;
            exp_q.push_back(e);
            #1;
            a_sack = a_sstb;
            #1;
            checks++;
            if (a_ack === 2'b00) begin
                failures++;
                $display("FAIL burst_ack i=%0d ack=%b grant=%b required ack=10", i, a_ack, a_grant);
            end else begin
                e = exp_q.pop_front();
                if (a_ack !== e.grant[1:0] || a_grant !== e.grant[1:0] || a_saddr !== e.addr ||
                    a_rdat !== e.data) begin
                    failures++;
                    $display("FAIL burst_xfer i=%0d ack=%b grant=%b addr=%h data=%h required %b/%b/%h/%h",
                             i, a_ack, a_grant, a_saddr, a_rdat, e.grant[1:0], e.grant[1:0],
                             e.addr, e.data);
                end
            end
        end
        @(negedge clk);
        a_sack = 1'b0; a_cyc[1] = 1'b0; a_stb[1] = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (a_grant !== 2'b00) begin
            failures++;
            $display("FAIL burst_release grant=%b required 00", a_grant);
        end
        @(negedge clk); #1;
        checks++;
        if (a_grant !== 2'b01) begin
            failures++;
            $display("FAIL burst_next_owner grant=%b required 01", a_grant);
        end
        a_cyc = 2'b00;
        repeat (2) @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_timeout();
        logic [1:0] exp_err;
        logic       exp_stb;
        a_addr[31:0] = 32'h4000; a_sack = 1'b0; a_serr = 1'b0;
        @(negedge clk);
        a_cyc = 2'b01; a_stb = 2'b01;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk); #1;
            exp_err = (k == 8) ? 2'b01 : 2'b00;
            exp_stb = (k != 9);
            checks++;
            if (a_err !== exp_err || a_ack !== 2'b00 || a_sstb !== exp_stb) begin
                failures++;
                $display("FAIL timeout cycle%0d err=%b ack=%b stb=%b required %b/00/%b",
                         k, a_err, a_ack, a_sstb, exp_err, exp_stb);
            end
        end
        a_cyc = 2'b00; a_stb = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_slave_err();
        logic [1:0] exp_err;
        logic       exp_stb;
        @(negedge clk);
        a_cyc = 2'b01; a_stb = 2'b01;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            a_serr = (k == 1 || k == 4);
            #1;
            exp_err = (k == 1 || k == 4 || k == 12) ? 2'b01 : 2'b00;
            exp_stb = (k != 13);
            checks++;
            if (a_err !== exp_err || a_ack !== 2'b00 || a_sstb !== exp_stb) begin
                failures++;
                $display("FAIL slave_err cycle%0d err=%b ack=%b stb=%b required %b/00/%b",
                         k, a_err, a_ack, a_sstb, exp_err, exp_stb);
            end
        end
        a_serr = 1'b0; a_cyc = 2'b00; a_stb = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_cyc = 2'b01; a_stb = 2'b01;
        repeat (2) @(negedge clk);
        rst = 1'b1; a_sack = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (a_scyc !== 1'b0 || a_sstb !== 1'b0 || a_grant !== 2'b00 || a_ack !== 2'b00 ||
            a_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid s_cyc=%b s_stb=%b grant=%b ack=%b busy=%b required 0/0/00/00/0",
                     a_scyc, a_sstb, a_grant, a_ack, a_busy);
        end
        @(negedge clk);
        rst = 1'b0; a_sack = 1'b0; a_cyc = 2'b00; a_stb = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        exp_t        e;
        int          waited, idle, ptr_m, owner;
        logic [2:0]  oh;
        b_we = 3'b111; b_sdin = 32'h0;
        for (int k = 0; k < 3; k++) begin
            b_addr[k*32 +: 32] = 32'h100 * 32'(k + 1) + 32'h40;
            b_wdat[k*32 +: 32] = 32'hA000_0000 + 32'(k);
            b_sel[k*4 +: 4]    = 4'(1 << k);
        end
        // Master 2 alone first, leaving the round-robin pointer at 2.
        b_cyc = 3'b100; b_stb = 3'b100;
        waited = 0;
        do begin
            @(negedge clk); #1; waited++;
        end while (b_grant === 3'b000 && waited < 8);
        b_sack = 1'b1;
        #1;
        checks++;
        if (b_grant !== 3'b100 || b_ack !== 3'b100) begin
            failures++;
            $display("FAIL rr_prime grant=%b ack=%b required 100/100", b_grant, b_ack);
        end
        @(negedge clk);
        b_sack = 1'b0; b_cyc = 3'b000; b_stb = 3'b000;
        repeat (2) @(negedge clk);

        ptr_m = 2;
        for (int t = 0; t < 4; t++) begin
            owner = (ptr_m + 1) % 3;
            e.grant = 3'(1 << owner);
            e.addr  = 32'h100 * 32'(owner + 1) + 32'h40;
            e.data  = 32'hA000_0000 + 32'(owner);
            e.sel   = 4'(1 << owner);
            e.we    = 1'b1;
            exp_q.push_back(e);
            ptr_m = owner;
        end
        for (int t = 0; t < 4; t++) begin
            idle = 0; waited = 0;
            do begin
                @(negedge clk);
                b_cyc = 3'b111; b_stb = 3'b111;
                #1;
                waited++;
                if (b_grant === 3'b000) idle++;
            end while (b_grant === 3'b000 && waited < 8);
            checks++;
            if (idle != 1) begin
                failures++;
                $display("FAIL rr_idle_gap t=%0d idle=%0d required 1", t, idle);
            end
            oh = b_grant;
            b_sack = 1'b1;
            #1;
            checks++;
            if (b_ack === 3'b000 || exp_q.size() == 0) begin
                failures++;
                $display("FAIL rr_ack t=%0d ack=%b grant=%b required one-hot ack", t, b_ack, b_grant);
            end else begin
                e = exp_q.pop_front();
                if (b_grant !== e.grant || b_ack !== e.grant || b_saddr !== e.addr ||
                    b_sdat !== e.data || b_ssel !== e.sel || b_swe !== e.we) begin
                    failures++;
                    $display("FAIL rr_xfer t=%0d grant=%b ack=%b addr=%h data=%h sel=%b we=%b required %b/%b/%h/%h/%b/%b",
                             t, b_grant, b_ack, b_saddr, b_sdat, b_ssel, b_swe, e.grant, e.grant,
                             e.addr, e.data, e.sel, e.we);
                end
            end
            @(negedge clk);
            b_sack = 1'b0;
            b_cyc = b_cyc & ~oh;
            b_stb = b_stb & ~oh;
        end
        b_cyc = 3'b000; b_stb = 3'b000;
        repeat (2) @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_no_timeout();
        int err_cnt = 0;
        b_sack = 1'b0; b_serr = 1'b0;
        @(negedge clk);
        b_cyc = 3'b001; b_stb = 3'b001;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk); #1;
            if (b_err !== 3'b000) err_cnt++;
        end
        checks++;
        if (err_cnt != 0 || b_grant !== 3'b001 || b_sstb !== 1'b1) begin
            failures++;
            $display("FAIL no_timeout errs=%0d grant=%b stb=%b required 0/001/1",
                     err_cnt, b_grant, b_sstb);
        end
        b_cyc = 3'b000; b_stb = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        a_cyc = '0; a_stb = '0; a_we = '0; a_sel = '0; a_addr = '0; a_wdat = '0;
        a_sdin = '0; a_sack = 1'b0; a_serr = 1'b0;
        b_cyc = '0; b_stb = '0; b_we = '0; b_sel = '0; b_addr = '0; b_wdat = '0;
        b_sdin = '0; b_sack = 1'b0; b_serr = 1'b0;
        test_reset();
        test_fixed();
        test_burst();
        test_timeout();
        test_slave_err();
        test_reset_mid();
        test_round_robin();
        test_no_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Parametrised N-master to 1-slave Wishbone arbiter. It lets the instruction-side and data-side wishbone_bus_if instances, plus any future masters such as a DMA engine, share one external Wishbone bus. It supports fixed-priority or round-robin arbitration and a per-transfer ack timeout that returns an error. It sits between the CPU bus-interface units and the SoC interconnect.

Parameters:
NUM_MASTERS, 2, number of master ports (2..8)
AW, 32, address width
DW, 32, data width; must be a multiple of 8
RR_MODE, 0, 0 = fixed priority (index 0 highest); 1 = round-robin
TIMEOUT, 255, cycles an unacked strobe may wait before an error is returned; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m_cyc_i  in  NUM_MASTERS  per-master cycle request
m_stb_i  in  NUM_MASTERS  per-master strobe
m_we_i  in  NUM_MASTERS  per-master write enable
m_sel_i  in  NUM_MASTERS*DW/8  byte selects; master k occupies slice k
m_addr_i  in  NUM_MASTERS*AW  addresses; master k occupies slice k
m_data_i  in  NUM_MASTERS*DW  write data; master k occupies slice k
m_data_o  out  DW  read data, broadcast to all masters
m_ack_o  out  NUM_MASTERS  per-master ack
m_err_o  out  NUM_MASTERS  per-master error termination
s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls
s_sel_o  out  DW/8  slave byte selects
s_addr_o  out  AW  slave address
s_data_o  out  DW  slave write data
s_data_i  in  DW  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave error
grant_o  out  NUM_MASTERS  one-hot current owner (registered)
busy_o  out  1  high while any master owns the bus

Behaviour:
- Clocking and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: state=IDLE, grant_o=0, rr_ptr=0, tmo_cnt=0, busy_o=0, all s_* outputs 0.
- A reset asserted mid-transfer drops s_cyc_o/s_stb_o at the next edge. No ack or err is forwarded after that edge.
- FSM states:
  - IDLE: if any m_cyc_i bit is set, select a winner. Next cycle: state=OWN, grant_o=onehot(winner). Arbitration latency is 1 cycle.
  - OWN: s_* outputs are driven combinationally from the granted master's slice.
  - OWN to IDLE at the edge where m_cyc_i[g]==0. On that edge grant_o clears, and rr_ptr:=g when RR_MODE=1.
  - The bus is never re-granted in the same cycle it is released. There is at least one IDLE cycle between owners.
- Fixed priority: the lowest requesting index wins.
- Round-robin: the search starts at (rr_ptr+1) mod NUM_MASTERS and wraps. The first requester found wins.
- Ownership is held for as long as the winner keeps cyc high, which allows back-to-back strobes. Requests from other masters are ignored during OWN.
- While IDLE, s_cyc_o=s_stb_o=s_we_o=0 and s_sel_o/s_addr_o/s_data_o=0.
- Response path (combinational):
  - m_data_o=s_data_i.
  - m_ack_o = grant_o & {N{s_ack_i}}.
  - m_err_o = grant_o & {N{s_err_i | tmo_hit}}.
  - Non-granted masters always see ack=err=0.
- Timeout counter:
  - In OWN, tmo_cnt increments each cycle that s_stb_o=1 and s_ack_i=s_err_i=0.
  - It clears on ack, on err, when strobe is low, and on leaving OWN.
  - tmo_hit = (TIMEOUT!=0) && (tmo_cnt==TIMEOUT-1) && stb && !ack && !err.
  - On tmo_hit, the granted master sees a one-cycle err and tmo_cnt clears. s_stb_o is forced 0 in the cycle after a hit, so the slave sees the strobe withdrawn.
  - The counter width is clog2(TIMEOUT+1), minimum 1.
- Simultaneous s_ack_i and tmo_hit cannot occur because tmo_hit requires !ack. Simultaneous s_ack_i and s_err_i are forwarded as-is; slave misbehaviour is not filtered.
- A master dropping cyc with stb still high releases the bus anyway. The s_* outputs fall with grant at the next edge; in the cycle cyc drops they still carry the master's stb, so the slave must qualify stb with cyc.

Decomposition:
- Shared package holds: the FSM state encoding (IDLE/OWN), RR_MODE constants, and a clog2 function.
- One sub-module, wb_arb_pick: combinational winner select given the request vector, rr_ptr and mode, returning a one-hot result. It is reusable by future interconnect blocks.
- Muxing and the timeout counter stay in the top module.

Test Plan:
- Reset: assert rst for 3 cycles while m_cyc_i=2'b11 -> grant_o=0, s_cyc_o=0, busy_o=0 throughout. First grant appears 1 cycle after rst falls, grant_o=2'b01.
- Fixed priority, NUM_MASTERS=2, RR_MODE=0: both masters request continuously and master 0 releases after each single read (addr 0x1000, s_data_i=0xDEADBEEF) -> every grant goes to 01. m_data_o=0xDEADBEEF with m_ack_o=01. Master 1 is never granted.
- Round-robin, NUM_MASTERS=3: all three request continuously, each releasing after one write -> grant sequence 001,010,100,001 with exactly one IDLE cycle between grants. s_addr_o/s_data_o/s_sel_o match the owner's slice.
- Burst hold: master 1 holds cyc for 4 strobes (addrs 0x0,0x4,0x8,0xC, slave acks each in 1 cycle) while master 0 requests -> grant stays 10 for all 4 acks. Master 0 is granted 2 cycles after master 1 drops cyc.
- Timeout, TIMEOUT=8: slave never acks -> m_err_o pulses for exactly 1 cycle on the 8th cycle of strobe. s_stb_o is 0 in the next cycle. TIMEOUT=0 -> no err after 1000 cycles.
- Slave error: s_err_i=1 on the first strobe cycle -> m_err_o = grant_o for that cycle, m_ack_o=0, tmo_cnt=0 afterwards.
